pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter of the single-cycle core and generates the PC-source select for the next-PC mux.
//  Each cycle it chooses PC+4, the branch target or the jump target. Selection priority: jump > branch > PC+4.
//  A boot/run/halt state machine gates fetch, and a retired-instruction counter tracks advances.
//  Sits between the control unit (branch/jump/halt decode) and instruction memory (pc, fetch_valid).
// PARAMETERS
//  RESET_VEC   32'h0000_0000  PC value loaded on reset
//  BOOT_CYCLES 4              cycles held in BOOT after reset before fetch starts (>=1)
//  TRAP_VEC    32'h0000_0080  redirect target on misaligned target (ALIGN_CHECK_EN only)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   synchronous, active-high reset
//  stall         in   1   freeze PC this cycle
//  halt          in   1   halt request from decode (one-cycle pulse or level)
//  branch_taken  in   1   Branch & Zero from control/ALU
//  branch_target in   32  PC+4 + (imm<<2)
//  jump          in   1   unconditional jump decoded
//  jump_target   in   32  jump destination
//  pc            out  32  current PC to instruction memory
//  pc_plus4      out  32  pc + 4, modulo 2^32
//  pc_src        out  1   next-PC mux select: 1 = branch_target, 0 = PC+4
//  fetch_valid   out  1   1 only in RUN; qualifies the instruction at pc
//  halted        out  1   1 in HALT state
//  instr_count   out  32  count of PC advances in RUN; wraps
//  misalign      out  1   one-cycle pulse on misaligned redirect; tied 0 without ALIGN_CHECK_EN
// BEHAVIOUR
//  Reset (sync, highest priority, any state): pc=RESET_VEC; state=BOOT; boot_cnt=0; instr_count=0;
//   fetch_valid=0; halted=0; misalign=0.
//  States:
//   BOOT: boot_cnt increments each cycle; go to RUN when boot_cnt==BOOT_CYCLES-1; pc held.
//   RUN: if halt, go to HALT; pc held, no count.
//        elif stall, pc held; no count.
//        else pc<=next_pc and instr_count++.
//   HALT: pc frozen; halted=1; exit only via reset.
//  next_pc: jump ? jump_target : branch_taken ? branch_target : pc_plus4.
//  pc_src = branch_taken & ~jump & (state==RUN), combinational; 0 in BOOT and HALT.
//  Simultaneous events: halt beats stall, and halt beats redirect. Branch/jump ignored while stalled.
//  All outputs other than pc_src and pc_plus4 are registered. Redirect latency is 1 cycle: target visible on pc next edge.
//  Wrap-around: pc_plus4 and instr_count wrap silently modulo 2^32.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//   - In RUN, with no stall and no halt: if next_pc[1:0]!=0, then pc<=TRAP_VEC, misalign=1 for one cycle, instr_count++.
//  ALIGN_CHECK_EN undefined:
//   - next_pc[1:0] forced to 2'b00; misalign tied 0; TRAP_VEC unused.
// STRUCTURE
//  Package pc_seq_pkg: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), PC width 32, PC_INC=4.
//  Sub-module next_pc_select: combinational priority select (jump/branch/pc_plus4).
//   - Produces next_pc and pc_src_raw.
//   - Instantiated once; the FSM, counters and PC register stay in pc_sequencer.
// TESTING
//  1. Reset, BOOT_CYCLES=4 -> fetch_valid=0 for 4 cycles, pc=0, then pc steps 0,4,8; instr_count=2 after 2 advances.
//  2. RUN at pc=0x10, branch_taken=1, branch_target=0x40 -> pc_src=1 same cycle; pc=0x40 next cycle.
//  3. jump=1 (target 0x100) with branch_taken=1 (target 0x40) -> pc=0x100, pc_src=0.
//  4. stall=1 for 3 cycles at pc=0x20 with branch pending -> pc stays 0x20, instr_count unchanged; advances after release.
//  5. halt with stall at pc=0x30 -> HALT, halted=1, pc=0x30 held for 10 cycles; reset -> pc=RESET_VEC, BOOT.
//  6. ALIGN_CHECK_EN, jump_target=0x102 -> pc=0x80, misalign pulses 1 cycle. Without the macro -> pc=0x100, misalign=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer: PC width,
// PC increment and the BOOT/RUN/HALT state encoding.
package pc_seq_pkg;

   localparam int PC_W = 32;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t PC_INC = 32'd4;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority select: jump beats branch beats sequential.
// pc_src_raw drives the external mux before state gating.
module next_pc_select
   import pc_seq_pkg::*;
(
   input  logic i_jump,
   input  pc_t  i_jump_target,
   input  logic i_branch_taken,
   input  pc_t  i_branch_target,
   input  pc_t  i_pc_plus4,
   output pc_t  o_next_pc,
   output logic o_pc_src_raw
);

   always_comb begin
      if (i_jump)
         o_next_pc = i_jump_target;
      else if (i_branch_taken)
         o_next_pc = i_branch_target;
      else
         o_next_pc = i_pc_plus4;
   end

   assign o_pc_src_raw = i_branch_taken & ~i_jump;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner with BOOT/RUN/HALT gating and retired-instruction count.
// Optional misaligned-target trapping is enabled by defining ALIGN_CHECK_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 4,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0080
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        halt,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_src,
   output logic        fetch_valid,
   output logic        halted,
   output logic [31:0] instr_count,
   output logic        misalign
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   logic [1:0]        r_state;
   logic [BOOT_W-1:0] r_boot_cnt;
   pc_t               r_pc;
   logic [31:0]       r_instr_count;
   logic              r_fetch_valid;
   logic              r_halted;
   logic              r_misalign;

   logic [1:0]        w_state_next;
   logic [BOOT_W-1:0] w_boot_next;
   pc_t               w_pc_next;
   logic [31:0]       w_count_next;
   logic              w_misalign_next;
   pc_t               w_pc_plus4;
   pc_t               w_next_pc;
   logic              w_pc_src_raw;

   assign w_pc_plus4 = r_pc + PC_INC;

   next_pc_select u_next_pc_select (
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_pc_plus4      (w_pc_plus4),
      .o_next_pc       (w_next_pc),
      .o_pc_src_raw    (w_pc_src_raw)
   );

`ifndef ALIGN_CHECK_EN
   // Trap vector only matters when alignment checking is built in.
   logic w_unused_trap;
   assign w_unused_trap = ^TRAP_VEC;
`endif

   always_comb begin
      w_state_next    = r_state;
      w_boot_next     = r_boot_cnt;
      w_pc_next       = r_pc;
      w_count_next    = r_instr_count;
      w_misalign_next = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_boot_next = r_boot_cnt + 1'b1;
            if (r_boot_cnt == BOOT_W'(BOOT_CYCLES - 1))
               w_state_next = ST_RUN;
         end
         ST_RUN: begin
            // halt wins over both stall and any redirect
            if (halt) begin
               w_state_next = ST_HALT;
            end else if (!stall) begin
               w_count_next = r_instr_count + 32'd1;
`ifdef ALIGN_CHECK_EN
               if (w_next_pc[1:0] != 2'b00) begin
                  w_pc_next       = TRAP_VEC;
                  w_misalign_next = 1'b1;
               end else begin
                  w_pc_next = w_next_pc;
               end
`else
               w_pc_next = {w_next_pc[31:2], 2'b00};
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_BOOT;
         r_boot_cnt    <= '0;
         r_pc          <= RESET_VEC;
         r_instr_count <= 32'd0;
         r_fetch_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_boot_cnt    <= w_boot_next;
         r_pc          <= w_pc_next;
         r_instr_count <= w_count_next;
         r_fetch_valid <= (w_state_next == ST_RUN);
         r_halted      <= (w_state_next == ST_HALT);
         r_misalign    <= w_misalign_next;
      end
   end

   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign pc_src      = w_pc_src_raw & (r_state == ST_RUN);
   assign fetch_valid = r_fetch_valid;
   assign halted      = r_halted;
   assign instr_count = r_instr_count;
   assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a cycle-level model
// of the sequencer's rules (boot delay, priority redirect, stall, halt).
module tb_pc_sequencer;

   localparam logic [31:0] RESET_VEC   = 32'h0000_0000;
   localparam int          BOOT_CYCLES = 4;
   localparam logic [31:0] TRAP_VEC    = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'd0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pc_src;
   logic        fetch_valid;
   logic        halted;
   logic [31:0] instr_count;
   logic        misalign;

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0 = booting, 1 = running, 2 = halted
   bit          m_valid = 0;
   int          m_mode;
   int          m_boot_elapsed;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_mis;

   pc_sequencer #(
      .RESET_VEC   (RESET_VEC),
      .BOOT_CYCLES (BOOT_CYCLES),
      .TRAP_VEC    (TRAP_VEC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .halt          (halt),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .pc_src        (pc_src),
      .fetch_valid   (fetch_valid),
      .halted        (halted),
      .instr_count   (instr_count),
      .misalign      (misalign)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic h, input logic bt,
                               input logic [31:0] btg, input logic j, input logic [31:0] jtg);
      logic [31:0] target;
      m_mis = 1'b0;
      if (r) begin
         m_valid        = 1;
         m_mode         = 0;
         m_boot_elapsed = 0;
         m_pc           = RESET_VEC;
         m_cnt          = 32'd0;
      end else if (!m_valid) begin
         // nothing known until the first reset
      end else if (m_mode == 0) begin
         m_boot_elapsed++;
         if (m_boot_elapsed == BOOT_CYCLES) m_mode = 1;
      end else if (m_mode == 1) begin
         if (h) begin
            m_mode = 2;
         end else if (!s) begin
            target = j ? jtg : (bt ? btg : m_pc + 32'd4);
            m_cnt  = m_cnt + 32'd1;
`ifdef ALIGN_CHECK_EN
            if (target % 4 != 0) begin
               m_pc  = TRAP_VEC;
               m_mis = 1'b1;
            end else begin
               m_pc = target;
            end
`else
            m_pc = target - (target % 4);
`endif
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic h, input logic bt,
                       input logic [31:0] btg, input logic j, input logic [31:0] jtg);
      @(negedge clk);
      reset = r; stall = s; halt = h;
      branch_taken = bt; branch_target = btg;
      jump = j; jump_target = jtg;
      #1;
      if (m_valid) begin
         check_val("pc",          pc,          m_pc);
         check_val("pc_plus4",    pc_plus4,    m_pc + 32'd4);
         check_val("pc_src",      {31'd0, pc_src},      {31'd0, (m_mode == 1) && bt && !j});
         check_val("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == 1});
         check_val("halted",      {31'd0, halted},      {31'd0, m_mode == 2});
         check_val("instr_count", instr_count, m_cnt);
         check_val("misalign",    {31'd0, misalign},    {31'd0, m_mis});
      end
      @(posedge clk);
      model_update(r, s, h, bt, btg, j, jtg);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, 0, 32'd0);
   endtask

   initial begin
      $display("[TB] reset and boot");
      step(1, 0, 0, 0, 32'd0, 0, 32'd0);
      step(1, 0, 0, 0, 32'd0, 0, 32'd0);
      idle(7);
      $display("[TB] branch at 0x10");
      step(0, 0, 0, 0, 32'd0, 1, 32'h10);
      step(0, 0, 0, 1, 32'h40, 0, 32'd0);
      $display("[TB] jump beats branch");
      step(0, 0, 0, 1, 32'h40, 1, 32'h100);
      idle(1);
      $display("[TB] stall with branch pending at 0x20");
      step(0, 0, 0, 0, 32'd0, 1, 32'h20);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'h200, 0, 32'd0);
      step(0, 0, 0, 1, 32'h200, 0, 32'd0);
      idle(1);
      $display("[TB] halt with stall at 0x30");
      step(0, 0, 0, 0, 32'd0, 1, 32'h30);
      step(0, 1, 1, 1, 32'h44, 1, 32'h48);
      idle(10);
      step(1, 0, 0, 0, 32'd0, 0, 32'd0);
      idle(6);
      $display("[TB] misaligned jump to 0x102");
      step(0, 0, 0, 0, 32'd0, 1, 32'h102);
      idle(2);
      step(0, 0, 0, 1, 32'h203, 0, 32'd0);
      idle(2);
      $display("[TB] pc wrap");
      step(0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC);
      idle(2);
      $display("[TB] random phase");
      for (int i = 0; i < 3000; i++) begin
         logic        r, s, h, bt, j;
         logic [31:0] btg, jtg;
         r   = ($urandom_range(0, 99) == 0);
         h   = ($urandom_range(0, 59) == 0);
         s   = ($urandom_range(0, 3) == 0);
         bt  = ($urandom_range(0, 2) == 0);
         j   = ($urandom_range(0, 4) == 0);
         btg = $urandom;
         jtg = $urandom;
         if ($urandom_range(0, 7) != 0) btg[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) jtg[1:0] = 2'b00;
         step(r, s, h, bt, btg, j, jtg);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
